bk_multiword_add_ctrl: RTL and testbench

- Sequencer that runs one WORD_W-bit Brent-Kung adder slice iteratively to perform multi-word add/subtract on operands held in word-addressed buffers.
- Word order is least significant first, with the carry chained through a register between words.
- Sits between the modexp control FSM (start/done) and the adder slice (A, B, Cin in; Sum, C_out back).
- Pipelined: one word per cycle after a one-cycle read latency.

---
 rtl/bk_multiword_add_ctrl.sv | 139 +++++++++++++
 tb/tb_bk_multiword_add_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bk_multiword_add_ctrl.sv
// Multi-word add/subtract sequencer driving one WORD_W-bit adder slice,
// least significant word first, carry chained through a register.
module bk_multiword_add_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned NW_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_sub,
  input  logic [NW_W-1:0]   num_words,
  input  logic              abort,
  output logic              ready,
  output logic              rd_en,
  output logic [NW_W-1:0]   rd_addr,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic [WORD_W-1:0] adder_a,
  output logic [WORD_W-1:0] adder_b,
  output logic              adder_cin,
  input  logic [WORD_W-1:0] adder_sum,
  input  logic              adder_cout,
  output logic              wr_en,
  output logic [NW_W-1:0]   wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              done,
  output logic              carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state;
  logic              op_q;
  logic [NW_W-1:0]   num_q;
  logic              vld;
  logic              carry_reg;
  logic              last_rd;

  // rd_addr doubles as the read index; the last read is index num_words-1
  assign last_rd = (rd_addr == (num_q - NW_W'(1)));

  // Sequencer, read issue, one-cycle data-valid pipeline and carry chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= 1'b0;
      num_q     <= '0;
      ready     <= 1'b1;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      vld       <= 1'b0;
      wr_addr   <= '0;
      carry_reg <= 1'b0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      vld     <= rd_en;
      wr_addr <= rd_addr;
      if (vld) begin
        carry_reg <= adder_cout;
      end
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op_sub;
            num_q     <= num_words;
            carry_reg <= op_sub;
            rd_addr   <= '0;
            ready     <= 1'b0;
            if (num_words == '0) begin
              state     <= FIN;
              done      <= 1'b1;
              carry_out <= op_sub;
            end else begin
              state <= RUN;
              rd_en <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
            rd_en <= 1'b0;
            vld   <= 1'b0;
          end else if (last_rd) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + NW_W'(1);
          end
        end
        DRAIN: begin
          vld <= 1'b0;
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            state     <= FIN;
            done      <= 1'b1;
            carry_out <= adder_cout;
          end
        end
        FIN: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          rd_en <= 1'b0;
          vld   <= 1'b0;
        end
      endcase
    end
  end

  // Adder slice operands: zeroed when no word is in flight
  always_comb begin
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    if (vld) begin
      adder_a   = a_word;
      adder_b   = op_q ? ~b_word : b_word;
      adder_cin = carry_reg;
    end
  end

  assign wr_en   = vld;
  assign wr_data = adder_sum;

endmodule

// File: tb/tb_bk_multiword_add_ctrl.sv
// Directed bench for bk_multiword_add_ctrl with a behavioural adder slice
// and word buffers.
module tb_bk_multiword_add_ctrl;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned NW_W   = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              op_sub;
  logic [NW_W-1:0]   num_words;
  logic              abort;
  logic              ready;
  logic              rd_en;
  logic [NW_W-1:0]   rd_addr;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] adder_a;
  logic [WORD_W-1:0] adder_b;
  logic              adder_cin;
  logic [WORD_W-1:0] adder_sum;
  logic              adder_cout;
  logic              wr_en;
  logic [NW_W-1:0]   wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              done;
  logic              carry_out;

  logic [WORD_W-1:0] a_mem [16];
  logic [WORD_W-1:0] b_mem [16];
  logic [WORD_W-1:0] res   [16];

  int checks;
  int errors;
  int rel;
  int rd_cnt;
  int wr_cnt;
  int first_wr;
  int last_wr;
  int done_rel;
  int done_cnt;
  logic [WORD_W-1:0] last_b;
  logic              last_cin;

  bk_multiword_add_ctrl #(.WORD_W(WORD_W), .NW_W(NW_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_sub     (op_sub),
    .num_words  (num_words),
    .abort      (abort),
    .ready      (ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .a_word     (a_word),
    .b_word     (b_word),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done),
    .carry_out  (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder slice
  assign {adder_cout, adder_sum} = 9'(adder_a) + 9'(adder_b) + 9'(adder_cin);

  // Operand buffers with one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      a_word <= a_mem[rd_addr];
      b_word <= b_mem[rd_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge and log activity
  task automatic tick();
    @(posedge clk);
    #1;
    rel++;
    if (rd_en) rd_cnt++;
    if (wr_en) begin
      wr_cnt++;
      if (first_wr == 0) first_wr = rel;
      last_wr  = rel;
      res[wr_addr] = wr_data;
      last_b   = adder_b;
      last_cin = adder_cin;
    end
    if (done) begin
      done_cnt++;
      if (done_rel == 0) done_rel = rel;
    end
  endtask

  task automatic clear_stats();
    rel = 0; rd_cnt = 0; wr_cnt = 0; first_wr = 0; last_wr = 0;
    done_rel = 0; done_cnt = 0; last_b = '0; last_cin = 1'b0;
    for (int i = 0; i < 16; i++) res[i] = 8'hAA;
  endtask

  // One operation: start on the next edge, then let it run to completion
  task automatic run_op(input logic sub, input int n);
    clear_stats();
    op_sub    = sub;
    num_words = 4'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    repeat (n + 3) tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; num_words = '0; abort = 1'b0;
    for (int i = 0; i < 16; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
    clear_stats();
    #12;
    check("rst_ready",  32'(ready), 32'd1);
    check("rst_rd_en",  32'(rd_en), 32'd0);
    check("rst_wr_en",  32'(wr_en), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_cout",   32'(carry_out), 32'd0);
    check("rst_rdaddr", 32'(rd_addr), 32'd0);
    check("rst_wraddr", 32'(wr_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Add n=2: 0xFF01 + 0x0100
    a_mem[0] = 8'h01; a_mem[1] = 8'hFF;
    b_mem[0] = 8'h00; b_mem[1] = 8'h01;
    run_op(1'b0, 2);
    check("add2_res0",   32'(res[0]), 32'h01);
    check("add2_res1",   32'(res[1]), 32'h00);
    check("add2_cout",   32'(carry_out), 32'd1);
    check("add2_done",   32'(done_rel), 32'd4);
    check("add2_rdcnt",  32'(rd_cnt), 32'd2);
    check("add2_wrfst",  32'(first_wr), 32'd2);
    check("add2_wrlst",  32'(last_wr), 32'd3);
    check("add2_ready",  32'(ready), 32'd1);

    // Add n=3: carry ripples through all three words
    for (int i = 0; i < 3; i++) begin a_mem[i] = 8'hFF; b_mem[i] = 8'h00; end
    b_mem[0] = 8'h01;
    run_op(1'b0, 3);
    check("add3_res0",  32'(res[0]), 32'h00);
    check("add3_res1",  32'(res[1]), 32'h00);
    check("add3_res2",  32'(res[2]), 32'h00);
    check("add3_cout",  32'(carry_out), 32'd1);
    check("add3_rdcnt", 32'(rd_cnt), 32'd3);
    check("add3_wrcnt", 32'(wr_cnt), 32'd3);
    check("add3_dcnt",  32'(done_cnt), 32'd1);

    // Subtract n=1: 0x05 - 0x07 borrows
    a_mem[0] = 8'h05; b_mem[0] = 8'h07;
    run_op(1'b1, 1);
    check("sub1_advb", 32'(last_b), 32'hF8);
    check("sub1_cin",  32'(last_cin), 32'd1);
    check("sub1_res0", 32'(res[0]), 32'hFE);
    check("sub1_cout", 32'(carry_out), 32'd0);
    check("sub1_done", 32'(done_rel), 32'd3);

    // Zero-length subtract: completes immediately with no buffer traffic
    run_op(1'b1, 0);
    check("n0_rdcnt", 32'(rd_cnt), 32'd0);
    check("n0_wrcnt", 32'(wr_cnt), 32'd0);
    check("n0_done",  32'(done_rel), 32'd1);
    check("n0_cout",  32'(carry_out), 32'd1);
    check("n0_ready", 32'(ready), 32'd1);

    // n=4 add with abort in the third cycle, start held high while running
    for (int i = 0; i < 4; i++) begin a_mem[i] = 8'h00; b_mem[i] = 8'h00; end
    clear_stats();
    op_sub = 1'b0; num_words = 4'd4; start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_ready4", 32'(ready), 32'd1);
    check("ab_rden4",  32'(rd_en), 32'd0);
    check("ab_wren4",  32'(wr_en), 32'd0);
    repeat (4) tick();
    check("ab_rdcnt", 32'(rd_cnt), 32'd3);
    check("ab_wrcnt", 32'(wr_cnt), 32'd2);
    check("ab_wrfst", 32'(first_wr), 32'd2);
    check("ab_wrlst", 32'(last_wr), 32'd3);
    check("ab_dcnt",  32'(done_cnt), 32'd0);
    check("ab_cout",  32'(carry_out), 32'd1);
    check("ab_res2",  32'(res[2]), 32'hAA);

    // Asynchronous reset in the middle of an n=5 run
    clear_stats();
    op_sub = 1'b0; num_words = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_ready",  32'(ready), 32'd1);
    check("ar_rden",   32'(rd_en), 32'd0);
    check("ar_wren",   32'(wr_en), 32'd0);
    check("ar_rdaddr", 32'(rd_addr), 32'd0);
    check("ar_wraddr", 32'(wr_addr), 32'd0);
    check("ar_cout",   32'(carry_out), 32'd0);
    #2 rst_n = 1'b1;
    a_mem[0] = 8'h10; b_mem[0] = 8'h20;
    run_op(1'b0, 1);
    check("ar_res0", 32'(res[0]), 32'h30);
    check("ar_cout2", 32'(carry_out), 32'd0);
    check("ar_done", 32'(done_rel), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
